// File: rtl/seg7_scan_display_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_scan_display_if : datapath-side and pin-side bundle for the    |
// | multiplexed 7-segment driver.                  Rev 1.0             |
// +--------------------------------------------------------------------+
interface seg7_scan_display_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     blank_mask;
  logic [DIGITS-1:0]     blink_mask;
  logic                  lz_suppress;
  logic [3:0]            brightness;
  logic [6:0]            seg;
  logic                  dp_n;
  logic [DIGITS-1:0]     ans;
  logic                  frame_done;

  modport master (
    output load, value, dp, blank_mask, blink_mask, lz_suppress, brightness,
    input  seg, dp_n, ans, frame_done
  );

  modport slave (
    input  load, value, dp, blank_mask, blink_mask, lz_suppress, brightness,
    output seg, dp_n, ans, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_display.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_scan_display : N-digit multiplexed 7-segment driver with       |
// | frame-synchronous loading, LZ suppression, blink/blank and PWM.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module seg7_scan_display #(
  parameter int DIGITS     = 4,
  parameter int SCAN_BITS  = 16,
  parameter int BLINK_BITS = 24
) (
  input  wire logic             clk,
  input  wire logic             reset,
  seg7_scan_display_if.slave    bus
);

  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

  logic [SCAN_BITS-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0]   shown_val_q, shown_val_d;
  logic [DIGITS-1:0]     shown_dp_q, shown_dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic [DIGITS-1:0]     ans_q, ans_d;
  logic                  frame_done_q, frame_done_d;

  logic                  presc_term;
  logic                  wrap;
  logic [3:0]            nibble;
  logic [3:0]            phase;
  logic [DIGITS-1:0]     lz_dark;
  logic                  all_zero;
  logic                  lit;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    presc_term = &presc_q;
    wrap       = presc_term && (idx_q == LAST_IDX);
    presc_d    = presc_q + 1'b1;
    blink_d    = blink_q + 1'b1;
    idx_d      = idx_q;
    if (presc_term) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end

    pend_val_d = bus.load ? bus.value : pend_val_q;
    pend_dp_d  = bus.load ? bus.dp    : pend_dp_q;
    // Using the next pending value lets a load on the boundary cycle land in this frame.
    shown_val_d = wrap ? pend_val_d : shown_val_q;
    shown_dp_d  = wrap ? pend_dp_d  : shown_dp_q;
  end

  // Leading-zero mask: a digit is dark when it and every digit to its left hold zero.
  always_comb begin
    all_zero = 1'b1;
    lz_dark  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero & (shown_val_q[i*4 +: 4] == 4'h0);
      lz_dark[i] = all_zero && (i != 0);
    end
  end

  always_comb begin
    nibble = shown_val_q[int'(idx_q)*4 +: 4];
    phase  = presc_q[SCAN_BITS-1 -: 4];
    lit    = !bus.blank_mask[idx_q]
          && !(bus.lz_suppress && lz_dark[idx_q])
          && !(bus.blink_mask[idx_q] && blink_q[BLINK_BITS-1])
          && (phase <= bus.brightness);

    ans_d        = '1;
    seg_d        = 7'h7F;
    dp_n_d       = 1'b1;
    frame_done_d = wrap;
    if (lit) begin
      ans_d  = ~(DIGITS'(1) << idx_q);
      seg_d  = hex_decode(nibble);
      dp_n_d = ~shown_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      blink_q      <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      shown_val_q  <= '0;
      shown_dp_q   <= '0;
      seg_q        <= 7'h7F;
      dp_n_q       <= 1'b1;
      ans_q        <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      blink_q      <= blink_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      shown_val_q  <= shown_val_d;
      shown_dp_q   <= shown_dp_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      ans_q        <= ans_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.ans        = ans_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire
